// File: rtl/robot_pkg.sv
// Shared types and helpers for the pipe-cleaning robot core.
// Heading codes, controller states, and the left/right turn maps.
// No logic of its own; imported by the controller, interface users and the nav step.
package robot_pkg;

    localparam int POS_W = 6;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        NORTH = 2'b00,
        SOUTH = 2'b01,
        EAST  = 2'b10,
        WEST  = 2'b11
    } orient_t;

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        FWD    = 2'b01,
        CLEAN  = 2'b10,
        STUCK  = 2'b11
    } state_t;

    // N->W, W->S, S->E, E->N
    function automatic orient_t turn_left(input orient_t o);
        case (o)
            NORTH:   return WEST;
            WEST:    return SOUTH;
            SOUTH:   return EAST;
            default: return NORTH;
        endcase
    endfunction

    // Inverse of turn_left: N->E, E->S, S->W, W->N
    function automatic orient_t turn_right(input orient_t o);
        case (o)
            NORTH:   return EAST;
            EAST:    return SOUTH;
            SOUTH:   return WEST;
            default: return NORTH;
        endcase
    endfunction

endpackage

// File: rtl/robot_if.sv
// World <-> robot signal bundle: sensor bits and step tick in, pose and status out.
// Pure wiring, no latency.
// No backpressure: the world issues step ticks, the robot acknowledges each one.
interface robot_if;
    logic       step_en;
    logic       head;
    logic       left;
    logic       under;
    logic [5:0] robot_row;
    logic [5:0] robot_column;
    logic [1:0] robot_orientation;
    logic       cleaning;
    logic       clean_done;
    logic       stuck;
    logic       step_ack;

    // World / testbench side
    modport master (
        output step_en, head, left, under,
        input  robot_row, robot_column, robot_orientation,
        input  cleaning, clean_done, stuck, step_ack
    );

    // Robot controller side
    modport slave (
        input  step_en, head, left, under,
        output robot_row, robot_column, robot_orientation,
        output cleaning, clean_done, stuck, step_ack
    );
endinterface

// File: rtl/robot_nav_step.sv
// Forward-move calculator: next cell for the current heading and whether it is blocked.
// Purely combinational.
// Map edges are reported as blocked so the position can never leave 1..ROWS / 1..COLS.
module robot_nav_step
    import robot_pkg::*;
#(
    parameter int ROWS = 10,
    parameter int COLS = 20
) (
    input  logic [POS_W-1:0] row,
    input  logic [POS_W-1:0] col,
    input  orient_t          orient,
    input  logic             head,
    output logic [POS_W-1:0] next_row,
    output logic [POS_W-1:0] next_col,
    output logic             blocked
);

    logic edge_hit;

    // Step one cell along the heading unless that would cross a map edge
    always_comb begin
        next_row = row;
        next_col = col;
        edge_hit = 1'b0;
        case (orient)
            NORTH:   if (row <= POS_W'(1))    edge_hit = 1'b1; else next_row = row - POS_W'(1);
            SOUTH:   if (row >= POS_W'(ROWS)) edge_hit = 1'b1; else next_row = row + POS_W'(1);
            EAST:    if (col >= POS_W'(COLS)) edge_hit = 1'b1; else next_col = col + POS_W'(1);
            default: if (col <= POS_W'(1))    edge_hit = 1'b1; else next_col = col - POS_W'(1);
        endcase
    end

    assign blocked = head | edge_hit;

endmodule

// File: rtl/robot_controller.sv
// Left-wall-following robot core; one action per step tick, pauses to clean garbage.
// All outputs registered: effects and step_ack appear the cycle after the sampling edge.
// No backpressure; step ticks are ignored only once stuck (ROBOT_STUCK_DETECT_EN builds only).
module robot_controller
    import robot_pkg::*;
#(
    parameter int          ROWS        = 10,
    parameter int          COLS        = 20,
    parameter int          INIT_ROW    = 1,
    parameter int          INIT_COL    = 1,
    parameter logic [1:0]  INIT_ORIENT = 2'b10,
    parameter int          CLEAN_STEPS = 3
) (
    input  logic  clock,
    input  logic  reset,
    robot_if.slave bus
);

    logic [POS_W-1:0] row_q, col_q;
    orient_t          orient_q;
    state_t           state_q;
    logic [CNT_W-1:0] clean_cnt_q;
    logic             cleaning_q, clean_done_q, step_ack_q;
    logic [POS_W-1:0] nxt_row, nxt_col;
    logic             blocked;

`ifdef ROBOT_STUCK_DETECT_EN
    logic [2:0] turn_cnt_q;
    logic       stuck_q;
`endif

    robot_nav_step #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_nav (
        .row      (row_q),
        .col      (col_q),
        .orient   (orient_q),
        .head     (bus.head),
        .next_row (nxt_row),
        .next_col (nxt_col),
        .blocked  (blocked)
    );

    // Wall-following FSM: every accepted step tick performs exactly one action
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_q        <= POS_W'(INIT_ROW);
            col_q        <= POS_W'(INIT_COL);
            orient_q     <= orient_t'(INIT_ORIENT);
            state_q      <= SEARCH;
            clean_cnt_q  <= '0;
            cleaning_q   <= 1'b0;
            clean_done_q <= 1'b0;
            step_ack_q   <= 1'b0;
`ifdef ROBOT_STUCK_DETECT_EN
            turn_cnt_q   <= '0;
            stuck_q      <= 1'b0;
`endif
        end else begin
            step_ack_q   <= 1'b0;
            clean_done_q <= 1'b0;
            if (bus.step_en && state_q != STUCK) begin
                step_ack_q <= 1'b1;
                case (state_q)
                    SEARCH: begin
                        if (bus.under) begin
                            state_q     <= CLEAN;
                            clean_cnt_q <= CNT_W'(CLEAN_STEPS - 1);
                            cleaning_q  <= 1'b1;
                        end else if (!bus.left) begin
                            orient_q <= turn_left(orient_q);
                            state_q  <= FWD;
`ifdef ROBOT_STUCK_DETECT_EN
                            turn_cnt_q <= '0;
`endif
                        end else if (!blocked) begin
                            row_q <= nxt_row;
                            col_q <= nxt_col;
`ifdef ROBOT_STUCK_DETECT_EN
                            turn_cnt_q <= '0;
`endif
                        end else begin
                            orient_q <= turn_right(orient_q);
`ifdef ROBOT_STUCK_DETECT_EN
                            // Fourth consecutive right turn: a full spin means boxed in
                            turn_cnt_q <= turn_cnt_q + 3'd1;
                            if (turn_cnt_q == 3'd3) begin
                                state_q <= STUCK;
                                stuck_q <= 1'b1;
                            end
`endif
                        end
                    end
                    FWD: begin
                        if (bus.under) begin
                            state_q     <= CLEAN;
                            clean_cnt_q <= CNT_W'(CLEAN_STEPS - 1);
                            cleaning_q  <= 1'b1;
                        end else if (!blocked) begin
                            row_q   <= nxt_row;
                            col_q   <= nxt_col;
                            state_q <= SEARCH;
`ifdef ROBOT_STUCK_DETECT_EN
                            turn_cnt_q <= '0;
`endif
                        end else begin
                            orient_q <= turn_right(orient_q);
                            state_q  <= SEARCH;
                        end
                    end
                    CLEAN: begin
                        if (clean_cnt_q != '0) begin
                            clean_cnt_q <= clean_cnt_q - CNT_W'(1);
                        end else begin
                            cleaning_q   <= 1'b0;
                            clean_done_q <= 1'b1;
                            state_q      <= SEARCH;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.robot_row         = row_q;
    assign bus.robot_column      = col_q;
    assign bus.robot_orientation = orient_q;
    assign bus.cleaning          = cleaning_q;
    assign bus.clean_done        = clean_done_q;
    assign bus.step_ack          = step_ack_q;
`ifdef ROBOT_STUCK_DETECT_EN
    assign bus.stuck             = stuck_q;
`else
    assign bus.stuck             = 1'b0;
`endif

endmodule

// File: tb/tb_robot_controller.sv
// Self-checking bench for robot_controller: table vectors, directed corner cases, random vs model.
// Outputs are sampled on the falling edge, one cycle after inputs are applied.
// Follows ROBOT_STUCK_DETECT_EN for the stuck expectations.
module tb_robot_controller;

    localparam int ROWS = 10;
    localparam int COLS = 20;
    localparam int CSTEPS = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    robot_if bus();

    robot_controller #(
        .ROWS(ROWS), .COLS(COLS), .INIT_ROW(1), .INIT_COL(1),
        .INIT_ORIENT(2'b10), .CLEAN_STEPS(CSTEPS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: heading 0=N 1=S 2=E 3=W, mode 0=search 1=forced 2=clean 3=stuck
    int m_row, m_col, m_dir, m_mode, m_cnt, m_spins;
    bit m_cleaning, m_done, m_stuck, m_ack;
    int left_of[4]  = '{3, 2, 0, 1};
    int right_of[4] = '{2, 3, 1, 0};
    int d_row[4]    = '{-1, 1, 0, 0};
    int d_col[4]    = '{0, 0, 1, -1};

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic void model_reset();
        m_row = 1; m_col = 1; m_dir = 2; m_mode = 0; m_cnt = 0; m_spins = 0;
        m_cleaning = 0; m_done = 0; m_stuck = 0; m_ack = 0;
    endfunction

    function automatic void model_apply(input bit en, input bit h, input bit l, input bit u);
        int nr, nc;
        bit blk;
        m_ack = 0;
        m_done = 0;
        if (!en || m_mode == 3) return;
        m_ack = 1;
        nr = m_row + d_row[m_dir];
        nc = m_col + d_col[m_dir];
        blk = h || nr < 1 || nr > ROWS || nc < 1 || nc > COLS;
        if (m_mode == 2) begin
            if (m_cnt > 0) m_cnt--;
            else begin m_cleaning = 0; m_done = 1; m_mode = 0; end
        end else if (u) begin
            m_mode = 2; m_cnt = CSTEPS - 1; m_cleaning = 1;
        end else if (m_mode == 0 && !l) begin
            m_dir = left_of[m_dir]; m_mode = 1; m_spins = 0;
        end else if (!blk) begin
            m_row = nr; m_col = nc; m_mode = 0; m_spins = 0;
        end else begin
            m_dir = right_of[m_dir];
`ifdef ROBOT_STUCK_DETECT_EN
            if (m_mode == 0) begin
                m_spins++;
                if (m_spins == 4) begin m_mode = 3; m_stuck = 1; end
            end
`endif
            if (m_mode == 1) m_mode = 0;
        end
    endfunction

    task automatic check_model(input string tag);
        chk({tag, " row"},      int'(bus.robot_row),         m_row);
        chk({tag, " col"},      int'(bus.robot_column),      m_col);
        chk({tag, " orient"},   int'(bus.robot_orientation), m_dir);
        chk({tag, " cleaning"}, int'(bus.cleaning),          int'(m_cleaning));
        chk({tag, " done"},     int'(bus.clean_done),        int'(m_done));
        chk({tag, " stuck"},    int'(bus.stuck),             int'(m_stuck));
        chk({tag, " ack"},      int'(bus.step_ack),          int'(m_ack));
    endtask

    // Apply one cycle of inputs at the falling edge, check at the next falling edge
    task automatic cycle(input bit en, input bit h, input bit l, input bit u, input string tag);
        bus.step_en = en; bus.head = h; bus.left = l; bus.under = u;
        model_apply(en, h, l, u);
        @(negedge clock);
        bus.step_en = 1'b0;
        check_model(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.step_en = 1'b0; bus.head = 1'b0; bus.left = 1'b1; bus.under = 1'b0;
        @(negedge clock);
        model_reset();
        check_model("reset");
        reset = 1'b0;
    endtask

    task automatic moves(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1, 0, 1, 0, tag);
    endtask

    typedef struct {
        bit en, h, l, u;
        int row, col, orient;
        bit cleaning, done, ack;
    } vec_t;

    vec_t vecs[13];

    initial begin
        bus.step_en = 1'b0; bus.head = 1'b0; bus.left = 1'b1; bus.under = 1'b0;

        vecs[0]  = '{1, 0, 1, 0, 1, 2, 2, 0, 0, 1};
        vecs[1]  = '{1, 0, 1, 0, 1, 3, 2, 0, 0, 1};
        vecs[2]  = '{1, 0, 1, 0, 1, 4, 2, 0, 0, 1};
        vecs[3]  = '{1, 0, 1, 0, 1, 5, 2, 0, 0, 1};
        vecs[4]  = '{1, 0, 1, 0, 1, 6, 2, 0, 0, 1};
        vecs[5]  = '{0, 0, 1, 0, 1, 6, 2, 0, 0, 0};
        vecs[6]  = '{1, 0, 1, 1, 1, 6, 2, 1, 0, 1};
        vecs[7]  = '{1, 0, 1, 0, 1, 6, 2, 1, 0, 1};
        vecs[8]  = '{1, 0, 1, 0, 1, 6, 2, 1, 0, 1};
        vecs[9]  = '{1, 0, 1, 0, 1, 6, 2, 0, 1, 1};
        vecs[10] = '{1, 0, 1, 0, 1, 7, 2, 0, 0, 1};
        vecs[11] = '{1, 1, 1, 0, 1, 7, 1, 0, 0, 1};
        vecs[12] = '{1, 0, 1, 0, 2, 7, 1, 0, 0, 1};

        // Table: straight run east, idle cycle, clean at (1,6), then wall turn
        do_reset();
        chk("reset row", int'(bus.robot_row), 1);
        chk("reset orient", int'(bus.robot_orientation), 2);
        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].en, vecs[i].h, vecs[i].l, vecs[i].u, "tbl model");
            chk($sformatf("tbl%0d row", i),      int'(bus.robot_row),         vecs[i].row);
            chk($sformatf("tbl%0d col", i),      int'(bus.robot_column),      vecs[i].col);
            chk($sformatf("tbl%0d orient", i),   int'(bus.robot_orientation), vecs[i].orient);
            chk($sformatf("tbl%0d cleaning", i), int'(bus.cleaning),          int'(vecs[i].cleaning));
            chk($sformatf("tbl%0d done", i),     int'(bus.clean_done),        int'(vecs[i].done));
            chk($sformatf("tbl%0d ack", i),      int'(bus.step_ack),          int'(vecs[i].ack));
        end

        // Right edge acts as a wall
        do_reset();
        moves(19, "edge run");
        chk("edge col20", int'(bus.robot_column), 20);
        cycle(1, 0, 1, 0, "edge turn");
        chk("edge orient S", int'(bus.robot_orientation), 1);
        chk("edge col held", int'(bus.robot_column), 20);
        cycle(1, 0, 1, 0, "edge down");
        chk("edge row2", int'(bus.robot_row), 2);

        // Left opening at (5,5) east forces one move north regardless of left
        do_reset();
        moves(4, "open a");
        cycle(1, 1, 1, 0, "open b");
        moves(4, "open c");
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, "open spin");
        chk("open at row5", int'(bus.robot_row), 5);
        chk("open at col5", int'(bus.robot_column), 5);
        chk("open at east", int'(bus.robot_orientation), 2);
        cycle(1, 0, 0, 0, "open left");
        chk("open north", int'(bus.robot_orientation), 0);
        cycle(1, 0, 0, 0, "open fwd");
        chk("open row4", int'(bus.robot_row), 4);
        chk("open col5", int'(bus.robot_column), 5);

        // Clean at (3,7): position held, pulse when count runs out, then resume
        do_reset();
        moves(6, "cln a");
        cycle(1, 1, 1, 0, "cln b");
        moves(2, "cln c");
        cycle(1, 0, 1, 1, "cln enter");
        chk("cln cleaning", int'(bus.cleaning), 1);
        cycle(1, 0, 1, 1, "cln s1");
        cycle(1, 0, 1, 1, "cln s2");
        chk("cln held row", int'(bus.robot_row), 3);
        chk("cln held col", int'(bus.robot_column), 7);
        cycle(1, 0, 1, 1, "cln s3");
        chk("cln done pulse", int'(bus.clean_done), 1);
        chk("cln dropped", int'(bus.cleaning), 0);
        cycle(1, 0, 1, 0, "cln resume");
        chk("cln resume row", int'(bus.robot_row), 4);
        chk("cln done cleared", int'(bus.clean_done), 0);

        // Boxed in: full spin
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, "box spin");
        chk("box orient E", int'(bus.robot_orientation), 2);
`ifdef ROBOT_STUCK_DETECT_EN
        chk("box stuck", int'(bus.stuck), 1);
        cycle(1, 0, 0, 0, "box frozen");
        chk("box no ack", int'(bus.step_ack), 0);
        chk("box frozen orient", int'(bus.robot_orientation), 2);
`else
        chk("box not stuck", int'(bus.stuck), 0);
        cycle(1, 1, 1, 0, "box spin on");
        chk("box orient S", int'(bus.robot_orientation), 1);
`endif

        // Reset asserted during CLEAN takes effect without a clock edge
        do_reset();
        moves(2, "rst a");
        cycle(1, 0, 1, 1, "rst clean");
        cycle(1, 0, 1, 0, "rst clean2");
        reset = 1'b1;
        #1;
        chk("rst row", int'(bus.robot_row), 1);
        chk("rst col", int'(bus.robot_column), 1);
        chk("rst orient", int'(bus.robot_orientation), 2);
        chk("rst cleaning", int'(bus.cleaning), 0);
        chk("rst done", int'(bus.clean_done), 0);
        @(negedge clock);
        chk("rst done hold", int'(bus.clean_done), 0);
        reset = 1'b0;
        model_reset();

        // Random traffic against the model, with periodic resets
        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 0) do_reset();
            cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 10, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
